// File: rtl/mux_layer_sequencer.sv
// Game-screen sequencer: walks TITLE/PLAY/DEATH_FLASH/GAME_OVER and gates mux layers per frame.
// Optional pause feature enabled by defining MUX_SEQ_PAUSE_EN.
module mux_layer_sequencer #(
  parameter int LIVES_W         = 2,
  parameter int LIVES_INIT      = 3,
  parameter int FLASH_FRAMES    = 60,
  parameter int FLASH_PERIOD    = 8,
  parameter int GAMEOVER_FRAMES = 180
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               startKey,
  input  logic               playerDied,
`ifdef MUX_SEQ_PAUSE_EN
  input  logic               pauseKey,
`endif
  output logic [5:0]         layerEnable,
  output logic               gameFrozen,
  output logic [LIVES_W-1:0] lives,
  output logic [2:0]         seqState
);

  typedef enum logic [2:0] {
    ST_TITLE       = 3'd0,
    ST_PLAY        = 3'd1,
    ST_DEATH_FLASH = 3'd2,
    ST_GAME_OVER   = 3'd3,
    ST_PAUSED      = 3'd4
  } state_t;

  localparam logic [5:0] MASK_TITLE = 6'b110000;
  localparam logic [5:0] MASK_PLAY  = 6'b101111;
  localparam logic [5:0] MASK_FLASH = 6'b101110;

  state_t             state, next_state;
  logic [LIVES_W-1:0] next_lives;
  logic [7:0]         frame_cnt;
  logic [7:0]         blink_idx;
  logic [5:0]         target_mask;
  logic               start_q, start_rise;
  logic               flash_done, gameover_done;

  assign start_rise    = startKey & ~start_q;
  assign flash_done    = startOfFrame && (frame_cnt == 8'(FLASH_FRAMES - 1));
  assign gameover_done = startOfFrame && (frame_cnt == 8'(GAMEOVER_FRAMES - 1));
  assign blink_idx     = frame_cnt / 8'(FLASH_PERIOD);

`ifdef MUX_SEQ_PAUSE_EN
  logic pause_q, pause_rise;
  assign pause_rise = pauseKey & ~pause_q;
`endif

  // Transition decisions and the mask each state wants; only the current state's inputs act.
  always_comb begin
    next_state  = state;
    next_lives  = lives;
    target_mask = MASK_TITLE;
    case (state)
      ST_TITLE: begin
        if (start_rise) begin
          next_state = ST_PLAY;
          next_lives = LIVES_W'(LIVES_INIT);
        end
      end
      ST_PLAY: begin
        target_mask = MASK_PLAY;
        if (playerDied) begin
          next_state = ST_DEATH_FLASH;
          next_lives = (lives == '0) ? '0 : lives - 1'b1;
        end
`ifdef MUX_SEQ_PAUSE_EN
        else if (pause_rise) begin
          next_state = ST_PAUSED;
        end
`endif
      end
      ST_DEATH_FLASH: begin
        target_mask = MASK_FLASH | {5'b0, ~blink_idx[0]};
        if (flash_done) begin
          next_state = (lives == '0) ? ST_GAME_OVER : ST_PLAY;
        end
      end
      ST_GAME_OVER: begin
        if (gameover_done) begin
          next_state = ST_TITLE;
        end
      end
`ifdef MUX_SEQ_PAUSE_EN
      ST_PAUSED: begin
        target_mask = MASK_PLAY;
        if (pause_rise) begin
          next_state = ST_PLAY;
        end
      end
`endif
      default: begin
        next_state = ST_TITLE;
      end
    endcase
  end

  // Status outputs follow the next state at once; the layer mask waits for a frame boundary.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= ST_TITLE;
      lives       <= '0;
      frame_cnt   <= '0;
      layerEnable <= MASK_TITLE;
      gameFrozen  <= 1'b1;
      seqState    <= 3'd0;
      start_q     <= 1'b0;
`ifdef MUX_SEQ_PAUSE_EN
      pause_q     <= 1'b0;
`endif
    end else begin
      start_q    <= startKey;
`ifdef MUX_SEQ_PAUSE_EN
      pause_q    <= pauseKey;
`endif
      state      <= next_state;
      lives      <= next_lives;
      seqState   <= next_state;
      gameFrozen <= (next_state != ST_PLAY);
      if (next_state != state) begin
        frame_cnt <= '0;
      end else if (startOfFrame && state != ST_PAUSED) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
      if (startOfFrame) begin
        layerEnable <= target_mask;
      end
    end
  end

endmodule

// File: tb/tb_mux_layer_sequencer.sv
// Directed self-checking bench for mux_layer_sequencer; pause scenario runs when MUX_SEQ_PAUSE_EN is defined.
module tb_mux_layer_sequencer;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame;
  logic       startKey;
  logic       playerDied;
`ifdef MUX_SEQ_PAUSE_EN
  logic       pauseKey;
`endif
  logic [5:0] layerEnable;
  logic       gameFrozen;
  logic [1:0] lives;
  logic [2:0] seqState;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mux_layer_sequencer #(
    .LIVES_W(2), .LIVES_INIT(3), .FLASH_FRAMES(60), .FLASH_PERIOD(8), .GAMEOVER_FRAMES(180)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .startOfFrame(startOfFrame),
    .startKey(startKey),
    .playerDied(playerDied),
`ifdef MUX_SEQ_PAUSE_EN
    .pauseKey(pauseKey),
`endif
    .layerEnable(layerEnable),
    .gameFrozen(gameFrozen),
    .lives(lives),
    .seqState(seqState)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    vectors++; if (layerEnable !== 6'b110000) begin miscompares++; $display("[TB] FAIL reset_mask: got %b expected %b", layerEnable, 6'b110000); end
    vectors++; if (lives !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_lives: got %0d expected 0", lives); end
    vectors++; if (seqState !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_state: got %0d expected 0", seqState); end
    vectors++; if (gameFrozen !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_frozen: got %b expected 1", gameFrozen); end
  endtask

  task automatic test_start();
    startKey = 1'b1;
    tick();
    startKey = 1'b0;
    vectors++; if (seqState !== 3'd1) begin miscompares++; $display("[TB] FAIL start_state: got %0d expected 1", seqState); end
    vectors++; if (lives !== 2'd3) begin miscompares++; $display("[TB] FAIL start_lives: got %0d expected 3", lives); end
    vectors++; if (gameFrozen !== 1'b0) begin miscompares++; $display("[TB] FAIL start_frozen: got %b expected 0", gameFrozen); end
    vectors++; if (layerEnable !== 6'b110000) begin miscompares++; $display("[TB] FAIL start_mask_before_frame: got %b expected %b", layerEnable, 6'b110000); end
    frames(1);
    vectors++; if (layerEnable !== 6'b101111) begin miscompares++; $display("[TB] FAIL start_mask_after_frame: got %b expected %b", layerEnable, 6'b101111); end
  endtask

  task automatic test_death_flash();
    logic [5:0] exp_mask;
    logic [2:0] exp_state;
    playerDied = 1'b1;
    tick();
    playerDied = 1'b0;
    vectors++; if (seqState !== 3'd2) begin miscompares++; $display("[TB] FAIL death_state: got %0d expected 2", seqState); end
    vectors++; if (lives !== 2'd2) begin miscompares++; $display("[TB] FAIL death_lives: got %0d expected 2", lives); end
    vectors++; if (gameFrozen !== 1'b1) begin miscompares++; $display("[TB] FAIL death_frozen: got %b expected 1", gameFrozen); end
    for (int k = 1; k <= 60; k++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      exp_mask  = ((((k - 1) / 8) % 2) == 0) ? 6'b101111 : 6'b101110;
      exp_state = (k == 60) ? 3'd1 : 3'd2;
      vectors++; if (layerEnable !== exp_mask) begin miscompares++; $display("[TB] FAIL flash_mask_frame%0d: got %b expected %b", k, layerEnable, exp_mask); end
      vectors++; if (seqState !== exp_state) begin miscompares++; $display("[TB] FAIL flash_state_frame%0d: got %0d expected %0d", k, seqState, exp_state); end
      tick();
    end
    vectors++; if (gameFrozen !== 1'b0) begin miscompares++; $display("[TB] FAIL flash_exit_frozen: got %b expected 0", gameFrozen); end
    frames(1);
    vectors++; if (layerEnable !== 6'b101111) begin miscompares++; $display("[TB] FAIL flash_exit_mask: got %b expected %b", layerEnable, 6'b101111); end
  endtask

  task automatic test_game_over();
    for (int d = 1; d >= 0; d--) begin
      playerDied = 1'b1;
      tick();
      playerDied = 1'b0;
      vectors++; if (lives !== 2'(d)) begin miscompares++; $display("[TB] FAIL go_lives_after_death: got %0d expected %0d", lives, d); end
      frames(59);
      vectors++; if (seqState !== 3'd2) begin miscompares++; $display("[TB] FAIL go_flash_hold: got %0d expected 2", seqState); end
      frames(1);
    end
    vectors++; if (seqState !== 3'd3) begin miscompares++; $display("[TB] FAIL go_state: got %0d expected 3", seqState); end
    vectors++; if (gameFrozen !== 1'b1) begin miscompares++; $display("[TB] FAIL go_frozen: got %b expected 1", gameFrozen); end
    frames(1);
    vectors++; if (layerEnable !== 6'b110000) begin miscompares++; $display("[TB] FAIL go_mask: got %b expected %b", layerEnable, 6'b110000); end
    startKey = 1'b1;
    tick();
    startKey = 1'b0;
    vectors++; if (seqState !== 3'd3) begin miscompares++; $display("[TB] FAIL go_startkey_ignored: got %0d expected 3", seqState); end
    playerDied = 1'b1;
    tick();
    playerDied = 1'b0;
    vectors++; if (seqState !== 3'd3) begin miscompares++; $display("[TB] FAIL go_died_ignored_state: got %0d expected 3", seqState); end
    vectors++; if (lives !== 2'd0) begin miscompares++; $display("[TB] FAIL go_died_ignored_lives: got %0d expected 0", lives); end
    frames(178);
    vectors++; if (seqState !== 3'd3) begin miscompares++; $display("[TB] FAIL go_hold_179: got %0d expected 3", seqState); end
    frames(1);
    vectors++; if (seqState !== 3'd0) begin miscompares++; $display("[TB] FAIL go_exit_title: got %0d expected 0", seqState); end
  endtask

  task automatic test_ignored_inputs();
    playerDied = 1'b1;
    tick();
    playerDied = 1'b0;
    vectors++; if (seqState !== 3'd0) begin miscompares++; $display("[TB] FAIL title_died_state: got %0d expected 0", seqState); end
    vectors++; if (lives !== 2'd0) begin miscompares++; $display("[TB] FAIL title_died_lives: got %0d expected 0", lives); end
    startKey = 1'b1;
    tick();
    startKey = 1'b0;
    playerDied = 1'b1;
    tick();
    playerDied = 1'b0;
    tick();
    playerDied = 1'b1;
    tick();
    playerDied = 1'b0;
    vectors++; if (seqState !== 3'd2) begin miscompares++; $display("[TB] FAIL flash_died_state: got %0d expected 2", seqState); end
    vectors++; if (lives !== 2'd2) begin miscompares++; $display("[TB] FAIL flash_died_lives: got %0d expected 2", lives); end
    frames(60);
    startKey = 1'b1;
    tick();
    startKey = 1'b0;
    vectors++; if (lives !== 2'd2) begin miscompares++; $display("[TB] FAIL play_startkey_lives: got %0d expected 2", lives); end
    vectors++; if (seqState !== 3'd1) begin miscompares++; $display("[TB] FAIL play_startkey_state: got %0d expected 1", seqState); end
  endtask

  task automatic test_back_to_back();
    playerDied   = 1'b1;
    startOfFrame = 1'b1;
    tick();
    playerDied   = 1'b0;
    startOfFrame = 1'b0;
    vectors++; if (seqState !== 3'd2) begin miscompares++; $display("[TB] FAIL b2b_state: got %0d expected 2", seqState); end
    vectors++; if (lives !== 2'd1) begin miscompares++; $display("[TB] FAIL b2b_lives: got %0d expected 1", lives); end
    frames(59);
    vectors++; if (seqState !== 3'd2) begin miscompares++; $display("[TB] FAIL b2b_frame_not_counted: got %0d expected 2", seqState); end
    frames(1);
    vectors++; if (seqState !== 3'd1) begin miscompares++; $display("[TB] FAIL b2b_exit: got %0d expected 1", seqState); end
  endtask

`ifdef MUX_SEQ_PAUSE_EN
  task automatic test_pause();
    pauseKey = 1'b1;
    tick();
    pauseKey = 1'b0;
    vectors++; if (seqState !== 3'd4) begin miscompares++; $display("[TB] FAIL pause_state: got %0d expected 4", seqState); end
    vectors++; if (gameFrozen !== 1'b1) begin miscompares++; $display("[TB] FAIL pause_frozen: got %b expected 1", gameFrozen); end
    frames(50);
    vectors++; if (layerEnable !== 6'b101111) begin miscompares++; $display("[TB] FAIL pause_mask: got %b expected %b", layerEnable, 6'b101111); end
    playerDied = 1'b1;
    tick();
    playerDied = 1'b0;
    vectors++; if (seqState !== 3'd4) begin miscompares++; $display("[TB] FAIL pause_died_state: got %0d expected 4", seqState); end
    vectors++; if (lives !== 2'd1) begin miscompares++; $display("[TB] FAIL pause_died_lives: got %0d expected 1", lives); end
    pauseKey = 1'b1;
    tick();
    pauseKey = 1'b0;
    vectors++; if (seqState !== 3'd1) begin miscompares++; $display("[TB] FAIL unpause_state: got %0d expected 1", seqState); end
    vectors++; if (gameFrozen !== 1'b0) begin miscompares++; $display("[TB] FAIL unpause_frozen: got %b expected 0", gameFrozen); end
  endtask
`endif

  task automatic test_reset_mid_play();
    resetN = 1'b0;
    #1;
    vectors++; if (layerEnable !== 6'b110000) begin miscompares++; $display("[TB] FAIL midreset_mask: got %b expected %b", layerEnable, 6'b110000); end
    vectors++; if (lives !== 2'd0) begin miscompares++; $display("[TB] FAIL midreset_lives: got %0d expected 0", lives); end
    vectors++; if (seqState !== 3'd0) begin miscompares++; $display("[TB] FAIL midreset_state: got %0d expected 0", seqState); end
    vectors++; if (gameFrozen !== 1'b1) begin miscompares++; $display("[TB] FAIL midreset_frozen: got %b expected 1", gameFrozen); end
    tick();
    startKey = 1'b1;
    resetN   = 1'b1;
    tick();
    startKey = 1'b0;
    vectors++; if (seqState !== 3'd1) begin miscompares++; $display("[TB] FAIL release_key_high_state: got %0d expected 1", seqState); end
    vectors++; if (lives !== 2'd3) begin miscompares++; $display("[TB] FAIL release_key_high_lives: got %0d expected 3", lives); end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    startKey     = 1'b0;
    playerDied   = 1'b0;
`ifdef MUX_SEQ_PAUSE_EN
    pauseKey     = 1'b0;
`endif
    #12;
    test_reset();
    resetN = 1'b1;
    tick();
    test_start();
    test_death_flash();
    test_game_over();
    test_ignored_inputs();
    test_back_to_back();
`ifdef MUX_SEQ_PAUSE_EN
    test_pause();
`endif
    test_reset_mid_play();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
